// File: rtl/mdu_if.sv
// Pipeline-to-MDU bus: launch handshake, MTHI/MTLO writes and the HI/LO results.
interface mdu_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        flush;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  // Execute stage drives the requests and watches busy/done.
  modport master (
    output start, op, rs, rt, flush, hi_we, lo_we, wdata,
    input  busy, done, hi, lo
  );

  // The multiply/divide unit itself.
  modport slave (
    input  start, op, rs, rt, flush, hi_we, lo_we, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide unit: MULT/MULTU/DIV/DIVU into HI/LO plus MTHI/MTLO.
// Magnitudes are processed unsigned (shift-add multiply, restoring divide);
// signs are stripped on launch and re-applied in the SIGN state.
module mdu_ctrl #(
  parameter int ITER = 32
) (
  input  logic clk,
  input  logic resetn,
  mdu_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;

  localparam int CW = $clog2(ITER);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  state_t        state, state_nx;
  logic [CW-1:0] count;
  logic          is_div;
  logic          neg_res;   // product / quotient negative
  logic          neg_rem;   // remainder negative
  logic [31:0]   opb;       // multiplicand or divisor magnitude
  logic [31:0]   acc;       // product high half or partial remainder
  logic [31:0]   shreg;     // multiplier (shifting out) or quotient (shifting in)
  logic [31:0]   hi_q, lo_q;
  logic          done_q;

  logic          launch;
  logic          sgn_op;
  logic [31:0]   abs_rs, abs_rt;
  logic [32:0]   mul_sum;
  logic [32:0]   div_sh;
  logic          div_ok;
  logic [31:0]   div_rem;
  logic [63:0]   prod_fix;
  logic [31:0]   quot_fix, rem_fix;

  assign launch = (state == IDLE) && bus.start && !bus.flush;
  assign sgn_op = !bus.op[0];
  assign abs_rs = (sgn_op && bus.rs[31]) ? -bus.rs : bus.rs;
  assign abs_rt = (sgn_op && bus.rt[31]) ? -bus.rt : bus.rt;

  // One shift-add step: conditional add with carry, then shift {acc, shreg} right.
  assign mul_sum = {1'b0, acc} + (shreg[0] ? {1'b0, opb} : 33'd0);

  // One restoring-divide step: shift in the next dividend bit, trial-subtract.
  assign div_sh  = {acc, shreg[31]};
  assign div_ok  = (div_sh >= {1'b0, opb});
  assign div_rem = div_ok ? 32'(div_sh - {1'b0, opb}) : div_sh[31:0];

  // Sign post-correction; divide-by-zero forces the DIVU quotient for DIV too,
  // while the negated remainder magnitude naturally reproduces rs.
  assign prod_fix = neg_res ? -{acc, shreg} : {acc, shreg};
  assign quot_fix = (opb == 32'd0) ? 32'hFFFF_FFFF : (neg_res ? -shreg : shreg);
  assign rem_fix  = neg_rem ? -acc : acc;

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  // Next-state logic; flush from any busy state returns to IDLE.
  always_comb begin
    // NOTE: default first so every path assigns state_nx and no latch is inferred.
    state_nx = state;
    unique case (state)
      IDLE:    if (launch) state_nx = CALC;
      CALC:    if (bus.flush) state_nx = IDLE;
               else if (count == LAST) state_nx = SIGN;
      SIGN:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: operand latch, iterations, result write-back and MT* writes.
  always_ff @(posedge clk) begin
    // NOTE: every register here, operands included, is reset, so a reset
    // mid-operation leaves no stale magnitude or sign state behind.
    if (!resetn) begin
      count   <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      opb     <= '0;
      acc     <= '0;
      shreg   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.hi_we) hi_q <= bus.wdata;
          if (bus.lo_we) lo_q <= bus.wdata;
          if (launch) begin
            count   <= '0;
            is_div  <= bus.op[1];
            neg_res <= sgn_op && (bus.rs[31] ^ bus.rt[31]);
            neg_rem <= sgn_op && bus.rs[31];
            acc     <= '0;
            // Multiply: opb=mcand, shreg=mplr. Divide: shreg=dividend, opb=divisor.
            opb     <= bus.op[1] ? abs_rt : abs_rs;
            shreg   <= bus.op[1] ? abs_rs : abs_rt;
          end
        end
        CALC: begin
          if (!bus.flush) begin
            count <= count + 1'b1;
            if (is_div) begin
              acc   <= div_rem;
              shreg <= {shreg[30:0], div_ok};
            end else begin
              acc   <= mul_sum[32:1];
              shreg <= {mul_sum[0], shreg[31:1]};
            end
          end
        end
        SIGN: begin
          if (!bus.flush) begin
            hi_q   <= is_div ? rem_fix  : prod_fix[63:32];
            lo_q   <= is_div ? quot_fix : prod_fix[31:0];
            done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule
